pmem_responder: RTL and testbench
=================================

# pmem_responder

Synthesizable physical-memory responder: the memory end of the line-wide pmem protocol that the cache arbiter drives. It accepts one line read or line write at a time, holds it for a programmable latency, and then pulses `pmem_resp`. It replaces the behavioural main-memory model at the top of the memory hierarchy and can also serve as the backing store below an L2. It also flags initiator protocol violations.

## Interface
- `DEPTH_LOG2`, default 8: number of line address bits used to index storage (2^DEPTH_LOG2 lines).
- `DELAY`, default 10: cycles from first request cycle to `pmem_resp`, legal range 1..255.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pmem_read` in 1: line read request, held by initiator until resp.
- `pmem_write` in 1: line write request, held by initiator until resp.
- `pmem_address` in `lc3b_pmem_addr` (16): byte address; bits [3:0] ignored (line offset).
- `pmem_wdata` in `lc3b_pmem_line` (128): write line, held with `pmem_write`.
- `pmem_resp` out 1: one-cycle completion pulse.
- `pmem_rdata` out `lc3b_pmem_line` (128): read line, valid in the `pmem_resp` cycle.
- `protocol_err` out 1: sticky violation flag, cleared only by reset.

## Operation
- Line index = `pmem_address[DEPTH_LOG2+3:4]`; higher address bits ignored (aliasing wrap-around).
- FSM states: IDLE, BUSY, RESP.
- IDLE: `pmem_read | pmem_write` sampled high → BUSY, counter loaded with DELAY-1. If DELAY = 1, go directly to RESP.
- BUSY: counter decrements each cycle. At counter = 1 → RESP. If both request lines are low at any edge → IDLE (abort), no write commit, `protocol_err` set.
- Transition into RESP: a read registers `storage[index]` into `pmem_rdata`; a write commits `pmem_wdata` to `storage[index]` at the same edge. Address and data are sampled at this edge, not at request start.
- RESP: `pmem_resp` = 1 for exactly one cycle, then → IDLE unconditionally.
- Read and write both high at any sampled edge: `protocol_err` set; treated as a write (no rdata update).
- Address or wdata change while in BUSY is not detected. The value at the RESP-entry edge wins.
- `pmem_rdata` holds its last read value until the next read completes. Writes do not alter it.
- Storage is not reset; contents survive `rst_n`. Simulation initial contents are all zero.

## Timing
- Reset values: `pmem_resp` 0, `pmem_rdata` 0, `protocol_err` 0, FSM IDLE, counter 0.
- Latency: request first high in cycle 0 → `pmem_resp` high in cycle DELAY.
- Back-to-back: the next request can be sampled in the cycle after RESP (IDLE). Minimum spacing between successive `pmem_resp` pulses is DELAY+1 cycles.
- Read-after-write to the same line, issued back-to-back, returns the new data.
- Reset asserted mid-BUSY: transaction aborted, no write commit, no resp.
- Reset asserted on the RESP-entry edge: the commit does not occur (async reset dominates).

## Structure
- Shared package `lc3b_types`: reuse `lc3b_pmem_line` and `lc3b_pmem_addr`; add the constant `PMEM_OFFSET_BITS = 4`.
- Sub-module `pmem_array`: DEPTH-line, 128-bit, single-port synchronous array (one write port, registered read), no reset.
- Top level contains the FSM, delay counter and error logic.

## Test plan
- Reset, then write 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 to 0x0040, then read 0x0040. Expect each `pmem_resp` exactly 10 cycles after request and `pmem_rdata` equal to the written line.
- DELAY = 1: read 0x0000 after reset. Expect `pmem_resp` in the next cycle, `pmem_rdata` = 0.
- Write A to 0x1230, then immediately read 0x1230 in the cycle after resp. Expect A, and resp pulses 11 cycles apart.
- Aliasing with DEPTH_LOG2 = 8: write B to 0x0010, then read 0x1010. Expect B.
- Assert read and write together with wdata C at 0x0200. Expect `protocol_err` = 1 and the line written with C. Drop `pmem_read` 3 cycles into a read: expect no `pmem_resp`, FSM back in IDLE.
- Pull `rst_n` low mid-BUSY of a write of D to 0x0300, then read 0x0300 after reset. Expect the old contents (not D), all outputs 0 during reset, and `protocol_err` cleared.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: pmem line/address widths and line offset size.
package lc3b_types;

  typedef logic [15:0]  lc3b_pmem_addr;
  typedef logic [127:0] lc3b_pmem_line;

  localparam int unsigned PMEM_OFFSET_BITS = 4;

endpackage

// File: rtl/pmem_if.sv
// Line-wide pmem request/response bundle between an initiator (cache arbiter) and memory.
interface pmem_if;
  import lc3b_types::*;

  logic          pmem_read;
  logic          pmem_write;
  lc3b_pmem_addr pmem_address;
  lc3b_pmem_line pmem_wdata;
  logic          pmem_resp;
  lc3b_pmem_line pmem_rdata;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );

endinterface

// File: rtl/pmem_array.sv
// Single-port line store: one write port, registered read; storage itself is never reset.
module pmem_array
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] index,
  input  lc3b_pmem_line         wdata,
  output lc3b_pmem_line         rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  lc3b_pmem_line mem [DEPTH];

  // An edge coinciding with reset assertion must not commit a write.
  always_ff @(posedge clk) begin
    if (we && rst_n) begin
      mem[index] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/pmem_responder.sv
// Physical-memory responder: serves one line read/write at a time after DELAY cycles,
// pulses pmem_resp, and raises a sticky flag on initiator protocol violations.
module pmem_responder
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned DELAY      = 10
) (
  input  logic    clk,
  input  logic    rst_n,
  pmem_if.slave   bus,
  output logic    protocol_err
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  resp;
  logic                  err_n;
  logic                  req_c, both_c, commit_c;
  logic                  wr_en_c, rd_en_c;
  logic [DEPTH_LOG2-1:0] index_c;
  lc3b_pmem_line         rdata;
  logic                  unused_addr_bits;

  assign req_c   = bus.pmem_read | bus.pmem_write;
  assign both_c  = bus.pmem_read & bus.pmem_write;
  // Higher address bits alias onto the same lines.
  assign index_c = bus.pmem_address[DEPTH_LOG2+PMEM_OFFSET_BITS-1:PMEM_OFFSET_BITS];
  assign unused_addr_bits = ^bus.pmem_address;

  // Next-state, counter and error logic; commit happens on the edge entering RESP.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    commit_c = 1'b0;
    err_n    = protocol_err | both_c;
    case (state)
      ST_IDLE: begin
        if (req_c) begin
          if (DELAY == 1) begin
            state_n  = ST_RESP;
            cnt_n    = '0;
            commit_c = 1'b1;
          end else begin
            state_n = ST_BUSY;
            cnt_n   = CNT_W'(DELAY - 1);
          end
        end
      end
      ST_BUSY: begin
        if (!req_c) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          err_n   = 1'b1;
        end else if (cnt == CNT_W'(1)) begin
          state_n  = ST_RESP;
          cnt_n    = '0;
          commit_c = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // A simultaneous read+write is handled as a write.
  assign wr_en_c = commit_c & bus.pmem_write;
  assign rd_en_c = commit_c & bus.pmem_read & ~bus.pmem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      resp         <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      resp         <= (state_n == ST_RESP);
      protocol_err <= err_n;
    end
  end

  pmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en_c),
    .re    (rd_en_c),
    .index (index_c),
    .wdata (bus.pmem_wdata),
    .rdata (rdata)
  );

  assign bus.pmem_resp  = resp;
  assign bus.pmem_rdata = rdata;

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: a DELAY=10 instance for the main sequence and a DELAY=1 instance.
module tb_pmem_responder;
  import lc3b_types::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic err0, err1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  localparam lc3b_pmem_line L1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam lc3b_pmem_line LA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam lc3b_pmem_line LB = 128'hBBBB_1111_2222_3333_4444_5555_6666_BBBB;
  localparam lc3b_pmem_line LC = 128'hCCCC_CCCC_0000_1234_5678_9ABC_DEF0_CCCC;
  localparam lc3b_pmem_line LD = 128'hDDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD;
  localparam lc3b_pmem_line LE = 128'hE0E1_E2E3_E4E5_E6E7_E8E9_EAEB_ECED_EEEF;

  pmem_if bus0 ();
  pmem_if bus1 ();

  pmem_responder #(.DEPTH_LOG2(8), .DELAY(10)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus0.slave),
    .protocol_err (err0)
  );

  pmem_responder #(.DEPTH_LOG2(8), .DELAY(1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus1.slave),
    .protocol_err (err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input lc3b_pmem_addr addr, input lc3b_pmem_line data);
    if (sel) begin
      bus1.pmem_read = rd; bus1.pmem_write = wr;
      bus1.pmem_address = addr; bus1.pmem_wdata = data;
    end else begin
      bus0.pmem_read = rd; bus0.pmem_write = wr;
      bus0.pmem_address = addr; bus0.pmem_wdata = data;
    end
  endtask

  // Issue one request in the next cycle, return latency (-1 on timeout) and resp cycle.
  task automatic xact(input bit sel, input bit rd, input bit wr, input lc3b_pmem_addr addr,
                      input lc3b_pmem_line data, output int lat, output int rcyc);
    logic r;
    @(posedge clk); #1;
    drive(sel, rd, wr, addr, data);
    lat  = -1;
    rcyc = -1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      r = sel ? bus1.pmem_resp : bus0.pmem_resp;
      if (r) begin
        lat  = i;
        rcyc = cyc;
        break;
      end
    end
    drive(sel, 1'b0, 1'b0, addr, data);
  endtask

  initial begin
    int lat, c1, c2;
    bit seen;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, '0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp",  128'(bus0.pmem_resp), 128'd0);
    chk("rst_rdata", bus0.pmem_rdata, 128'd0);
    chk("rst_err",   128'(err0), 128'd0);
    chk("rst_err1",  128'(err1), 128'd0);
    @(negedge clk) rst_n = 1'b1;

    xact(1'b0, 1'b0, 1'b1, 16'h0040, L1, lat, c1);
    chk("wr40_lat", 128'(lat), 128'd10);
    xact(1'b0, 1'b1, 1'b0, 16'h0040, '0, lat, c1);
    chk("rd40_lat", 128'(lat), 128'd10);
    chk("rd40_data", bus0.pmem_rdata, L1);
    chk("rd40_err", 128'(err0), 128'd0);

    xact(1'b1, 1'b1, 1'b0, 16'h0000, '0, lat, c1);
    chk("d1_lat", 128'(lat), 128'd1);
    chk("d1_data", bus1.pmem_rdata, 128'd0);

    xact(1'b0, 1'b0, 1'b1, 16'h1230, LA, lat, c1);
    xact(1'b0, 1'b1, 1'b0, 16'h1230, '0, lat, c2);
    chk("raw_data", bus0.pmem_rdata, LA);
    chk("raw_spacing", 128'(c2 - c1), 128'd11);
    @(posedge clk); #1;
    chk("resp_one_cycle", 128'(bus0.pmem_resp), 128'd0);

    xact(1'b0, 1'b0, 1'b1, 16'h0010, LB, lat, c1);
    xact(1'b0, 1'b1, 1'b0, 16'h1010, '0, lat, c1);
    chk("alias_data", bus0.pmem_rdata, LB);

    xact(1'b0, 1'b1, 1'b1, 16'h0200, LC, lat, c1);
    chk("both_lat", 128'(lat), 128'd10);
    chk("both_err", 128'(err0), 128'd1);
    chk("both_rdata_held", bus0.pmem_rdata, LB);
    xact(1'b0, 1'b1, 1'b0, 16'h0200, '0, lat, c1);
    chk("both_written", bus0.pmem_rdata, LC);

    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 16'h0040, '0);
    repeat (3) begin @(posedge clk); #1; end
    drive(1'b0, 1'b0, 1'b0, 16'h0040, '0);
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus0.pmem_resp) seen = 1'b1;
    end
    chk("abort_no_resp", 128'(seen), 128'd0);
    xact(1'b0, 1'b1, 1'b0, 16'h0040, '0, lat, c1);
    chk("post_abort_lat", 128'(lat), 128'd10);
    chk("post_abort_data", bus0.pmem_rdata, L1);

    xact(1'b0, 1'b0, 1'b1, 16'h0300, LE, lat, c1);
    chk("wrE_lat", 128'(lat), 128'd10);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 16'h0300, LD);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_resp",  128'(bus0.pmem_resp), 128'd0);
    chk("midrst_rdata", bus0.pmem_rdata, 128'd0);
    chk("midrst_err",   128'(err0), 128'd0);
    drive(1'b0, 1'b0, 1'b0, 16'h0300, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    xact(1'b0, 1'b1, 1'b0, 16'h0300, '0, lat, c1);
    chk("postrst_lat", 128'(lat), 128'd10);
    chk("postrst_data", bus0.pmem_rdata, LE);
    chk("postrst_err", 128'(err0), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
